// File: rtl/approx_adder_pipe_mon.sv
// Two-stage pipelined approximate adder (exact / LOA / truncate) with an
// error monitor that tracks transaction, exceed and worst-error statistics.
module approx_adder_pipe_mon #(
  parameter int WIDTH = 3,
  parameter int K     = 1,
  parameter int ET    = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_sum,
  output logic [WIDTH:0]     out_err,
  output logic               out_exceed,
  input  logic               stats_clr,
  output logic [CNT_W-1:0]   txn_count,
  output logic [CNT_W-1:0]   exceed_count,
  output logic [WIDTH:0]     max_err
);

  localparam int          HW      = WIDTH - K;
  localparam logic [31:0] ET_U    = 32'(ET);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]         mode_q, mode_d;
  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH:0]     sum_q, sum_d, err_q, err_d;
  logic               exceed_q, exceed_d;
  logic [CNT_W-1:0]   txn_q, txn_d, exc_cnt_q, exc_cnt_d;
  logic [WIDTH:0]     max_err_q, max_err_d;

  logic               in_fire_s, out_fire_s, adv_s;
  logic [WIDTH:0]     exact_s, approx_s, abs_err_s;
  logic [HW:0]        upper_s;
  logic [K-1:0]       lower_s;
  logic               carry_s, exceed_s;

  // S2 may refill whenever it is empty or its result is being taken.
  assign adv_s      = !s2_valid_q | out_ready;
  assign in_ready   = !s1_valid_q | !s2_valid_q | out_ready;
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = s2_valid_q & out_ready;

  // Exact and approximate sums of the S1 operands, plus their distance.
  always_comb begin
    exact_s  = {1'b0, a_q} + {1'b0, b_q};
    carry_s  = a_q[K-1] & b_q[K-1];
    lower_s  = '0;
    upper_s  = '0;
    approx_s = exact_s;
    case (mode_q)
      2'd1: begin
        lower_s  = a_q[K-1:0] | b_q[K-1:0];
        upper_s  = {1'b0, a_q[WIDTH-1:K]} + {1'b0, b_q[WIDTH-1:K]} + {{HW{1'b0}}, carry_s};
        approx_s = {upper_s, lower_s};
      end
      2'd2: begin
        lower_s  = '0;
        upper_s  = {1'b0, a_q[WIDTH-1:K]} + {1'b0, b_q[WIDTH-1:K]};
        approx_s = {upper_s, lower_s};
      end
      default: approx_s = exact_s;
    endcase
    if (exact_s >= approx_s) begin
      abs_err_s = exact_s - approx_s;
    end else begin
      abs_err_s = approx_s - exact_s;
    end
    exceed_s = (32'(abs_err_s) > ET_U);
  end

  // Pipeline stage next-state: S1 captures on input handshake, S2 on advance.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;
    err_d      = err_q;
    exceed_d   = exceed_q;
    if (in_fire_s) begin
      s1_valid_d = 1'b1;
      a_d        = in_a;
      b_d        = in_b;
      mode_d     = in_mode;
    end else if (adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d    = approx_s;
        err_d    = abs_err_s;
        exceed_d = exceed_s;
      end else begin
        sum_d    = sum_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Statistics: a clear overrides any handshake in the same cycle.
  always_comb begin
    txn_d     = txn_q;
    exc_cnt_d = exc_cnt_q;
    max_err_d = max_err_q;
    if (stats_clr) begin
      txn_d     = '0;
      exc_cnt_d = '0;
      max_err_d = '0;
    end else if (out_fire_s) begin
      if (txn_q != CNT_MAX) begin
        txn_d = txn_q + CNT_W'(1);
      end else begin
        txn_d = txn_q;
      end
      if (exceed_q && (exc_cnt_q != CNT_MAX)) begin
        exc_cnt_d = exc_cnt_q + CNT_W'(1);
      end else begin
        exc_cnt_d = exc_cnt_q;
      end
      if (err_q > max_err_q) begin
        max_err_d = err_q;
      end else begin
        max_err_d = max_err_q;
      end
    end else begin
      txn_d = txn_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= 2'd0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      err_q      <= '0;
      exceed_q   <= 1'b0;
      txn_q      <= '0;
      exc_cnt_q  <= '0;
      max_err_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
      exceed_q   <= exceed_d;
      txn_q      <= txn_d;
      exc_cnt_q  <= exc_cnt_d;
      max_err_q  <= max_err_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_sum      = sum_q;
  assign out_err      = err_q;
  assign out_exceed   = exceed_q;
  assign txn_count    = txn_q;
  assign exceed_count = exc_cnt_q;
  assign max_err      = max_err_q;

endmodule

// File: tb/tb_approx_adder_pipe_mon.sv
// Scoreboard bench: two instances (K=1/CNT_W=16 and K=2/CNT_W=2) share stimulus;
// a negedge monitor compares outputs, in_ready and statistics against a model.
module tb_approx_adder_pipe_mon;

  localparam int ET = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       stats_clr = 1'b0;
  logic [2:0] in_a = 3'd0;
  logic [2:0] in_b = 3'd0;
  logic [1:0] in_mode = 2'd0;

  logic        in_ready0, out_valid0, out_exceed0;
  logic [3:0]  out_sum0, out_err0, maxe0;
  logic [15:0] txn0, exc0;
  logic        in_ready1, out_valid1, out_exceed1;
  logic [3:0]  out_sum1, out_err1, maxe1;
  logic [1:0]  txn1, exc1;

  approx_adder_pipe_mon #(.WIDTH(3), .K(1), .ET(ET), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid0),
    .out_ready(out_ready), .out_sum(out_sum0), .out_err(out_err0),
    .out_exceed(out_exceed0), .stats_clr(stats_clr), .txn_count(txn0),
    .exceed_count(exc0), .max_err(maxe0));

  approx_adder_pipe_mon #(.WIDTH(3), .K(2), .ET(ET), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid1),
    .out_ready(out_ready), .out_sum(out_sum1), .out_err(out_err1),
    .out_exceed(out_exceed1), .stats_clr(stats_clr), .txn_count(txn1),
    .exceed_count(exc1), .max_err(maxe1));

  always #5 clk = ~clk;

  typedef struct {int sum; int err; int exc;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t h0, h1;
  int m_txn0, m_exc0, m_max0, m_txn1, m_exc1, m_max1;
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int m, input int k);
    exp_t r;
    int p2, ex, ap, c;
    p2 = 1 << k;
    ex = a + b;
    case (m)
      1: begin
        c  = ((a >> (k - 1)) & 1) & ((b >> (k - 1)) & 1);
        ap = ((a >> k) + (b >> k) + c) * p2 + ((a % p2) | (b % p2));
      end
      2: ap = ((a >> k) + (b >> k)) * p2;
      default: ap = ex;
    endcase
    r.sum = ap;
    r.err = (ex > ap) ? ex - ap : ap - ex;
    r.exc = (r.err > ET) ? 1 : 0;
    return r;
  endfunction

  task automatic upd(inout int t, inout int x, inout int mx, input exp_t h, input int cmax);
    if (t < cmax) t++;
    if (h.exc != 0 && x < cmax) x++;
    if (h.err > mx) mx = h.err;
  endtask

  // Monitor: everything is stable at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      m_txn0 = 0; m_exc0 = 0; m_max0 = 0;
      m_txn1 = 0; m_exc1 = 0; m_max1 = 0;
    end else begin
      chk("txn0", txn0, m_txn0);
      chk("exc0", exc0, m_exc0);
      chk("maxe0", maxe0, m_max0);
      chk("txn1", txn1, m_txn1);
      chk("exc1", exc1, m_exc1);
      chk("maxe1", maxe1, m_max1);
      chk("in_ready0", in_ready0, (q0.size() < 2) || out_ready);
      chk("in_ready1", in_ready1, (q1.size() < 2) || out_ready);
      if (out_valid0) begin
        if (q0.size() == 0) chk("spurious0", out_valid0, 0);
        else begin
          h0 = q0[0];
          chk("sum0", out_sum0, h0.sum);
          chk("err0", out_err0, h0.err);
          chk("exceed0", out_exceed0, h0.exc);
          if (out_ready) begin
            void'(q0.pop_front());
            if (!stats_clr) upd(m_txn0, m_exc0, m_max0, h0, 65535);
          end
        end
      end
      if (out_valid1) begin
        if (q1.size() == 0) chk("spurious1", out_valid1, 0);
        else begin
          h1 = q1[0];
          chk("sum1", out_sum1, h1.sum);
          chk("err1", out_err1, h1.err);
          chk("exceed1", out_exceed1, h1.exc);
          if (out_ready) begin
            void'(q1.pop_front());
            if (!stats_clr) upd(m_txn1, m_exc1, m_max1, h1, 3);
          end
        end
      end
      if (stats_clr) begin
        m_txn0 = 0; m_exc0 = 0; m_max0 = 0;
        m_txn1 = 0; m_exc1 = 0; m_max1 = 0;
      end
      if (in_valid && in_ready0) q0.push_back(model(int'(in_a), int'(in_b), int'(in_mode), 1));
      if (in_valid && in_ready1) q1.push_back(model(int'(in_a), int'(in_b), int'(in_mode), 2));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int m);
    bit ok;
    ok = 1'b0;
    in_a = 3'(a); in_b = 3'(b); in_mode = 2'(m); in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready0) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    cyc();
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      cyc();
    end
    chk("drain", q0.size() + q1.size(), 0);
    cyc();
    cyc();
  endtask

  initial begin
    int idx;
    bit saw_drop;
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid0, 0);
    chk("rst_sum", out_sum0, 0);
    chk("rst_err", out_err0, 0);
    chk("rst_exceed", out_exceed0, 0);
    chk("rst_ready", in_ready0, 1);
    chk("rst_txn", txn0, 0);
    cyc();

    send(3, 1, 0);
    @(negedge clk);
    chk("lat_early", out_valid0, 0);
    @(negedge clk);
    chk("lat", out_valid0, 1);
    chk("lat_sum", out_sum0, 4);
    cyc();
    cyc();
    @(negedge clk);
    chk("txn_first", txn0, 1);
    cyc();

    send(3, 1, 1);
    send(3, 1, 2);
    wait_idle();
    chk("max_err0", maxe0, 2);

    send(3, 3, 2);
    send(7, 7, 1);
    wait_idle();
    chk("k2_exceed_cnt", exc1, 1);
    chk("k2_max_err", maxe1, 6);

    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    idx = 0;
    saw_drop = 1'b0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid = 1'b1;
      in_a = 3'(idx); in_b = 3'(7 - idx); in_mode = 2'(idx % 4);
      @(negedge clk);
      if (in_ready0) idx++;
      else saw_drop = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    chk("stream_count", idx, 8);
    chk("stream_drop", saw_drop, 1);
    chk("stream_txn", txn0, 8);

    out_ready = 1'b0;
    send(1, 2, 0);
    send(2, 3, 1);
    @(negedge clk);
    chk("full_ready", in_ready0, 0);
    cyc();
    rst = 1'b1;
    out_ready = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", out_valid0, 0);
    chk("midrst_txn", txn0, 0);
    chk("midrst_max", maxe0, 0);
    cyc();

    for (int i = 0; i < 5; i++) send(i, i + 1, 0);
    wait_idle();
    chk("sat_txn1", txn1, 3);
    chk("txn0_five", txn0, 5);

    out_ready = 1'b0;
    send(3, 3, 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid1) break;
    end
    cyc();
    stats_clr = 1'b1;
    out_ready = 1'b1;
    cyc();
    stats_clr = 1'b0;
    @(negedge clk);
    chk("clr_txn1", txn1, 0);
    chk("clr_exc1", exc1, 0);
    chk("clr_max1", maxe1, 0);
    chk("clr_txn0", txn0, 0);
    cyc();

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 3'($urandom_range(0, 7));
      in_b      = 3'($urandom_range(0, 7));
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      stats_clr = ($urandom_range(0, 39) == 0);
      cyc();
    end
    in_valid = 1'b0;
    stats_clr = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/approx_adder_pipe_mon.md
Name: approx_adder_pipe_mon

Overview:
- Parametrised, pipelined successor to the fixed 3+3-bit SOP-approximated adders.
- Adds two WIDTH-bit operands using a per-transaction selectable approximation mode: exact, lower-part OR (LOA), or lower-part truncation.
- Computes the exact sum in parallel and tracks the absolute error against threshold ET in a monitor.
- Sits between operand producers and an accuracy-characterisation harness, with valid/ready on both sides.

Parameters:
- WIDTH, 3, operand width in bits (>=2).
- K, 1, number of approximated low bits (1 <= K < WIDTH).
- ET, 4, error threshold; a transaction exceeds when abs error > ET.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept an operand transaction.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_mode  in  2  0 exact, 1 LOA, 2 truncate, 3 treated as exact.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH+1  approximate sum.
- out_err  out  WIDTH+1  abs(exact - approximate).
- out_exceed  out  1  out_err > ET.
- stats_clr  in  1  synchronous clear of statistics.
- txn_count  out  CNT_W  completed output handshakes, saturating.
- exceed_count  out  CNT_W  completed handshakes with out_exceed=1, saturating.
- max_err  out  WIDTH+1  largest out_err among completed handshakes.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: in_ready=1, out_valid=0, out_sum=0, out_err=0, out_exceed=0, txn_count=0, exceed_count=0, max_err=0.
  - Reset mid-operation discards both pipeline stages; no handshake completes in the reset cycle.
- Pipeline, two stages:
  - S1 registers a, b and mode on the input handshake (in_valid & in_ready).
  - S2 registers out_sum, out_err and out_exceed computed from S1.
  - Latency is 2 cycles from input handshake to out_valid with no backpressure. Throughput is 1 per cycle.
- Stall rules:
  - S2 advances when !s2_valid | out_ready.
  - S1 advances into S2 under the same condition.
  - in_ready = !s1_valid | !s2_valid | out_ready (combinational from out_ready).
  - While out_valid=1 & out_ready=0, out_sum, out_err and out_exceed hold stable.
  - No transaction is lost or duplicated.
- Exact sum: a + b, WIDTH+1 bits.
- Mode 1 (LOA):
  - Low K bits = a[K-1:0] | b[K-1:0].
  - Carry c = a[K-1] & b[K-1].
  - Upper bits = a[W-1:K] + b[W-1:K] + c, (WIDTH-K+1) bits, placed at sum[W:K].
- Mode 2 (truncate): low K bits = 0; upper = a[W-1:K] + b[W-1:K].
- Modes 0 and 3: out_sum = exact.
- out_err is an unsigned absolute difference; it never wraps.
- Monitor, updated on the output handshake (out_valid & out_ready):
  - txn_count += 1.
  - exceed_count += out_exceed.
  - max_err = max(max_err, out_err).
  - Counters saturate at 2^CNT_W-1.
- stats_clr:
  - Zeros txn_count, exceed_count and max_err next cycle.
  - If asserted together with a handshake, the clear wins; that handshake is not counted.
  - The pipeline is unaffected.

Test Plan:
- Reset, then in_a=3, in_b=1, mode=0 -> 2 cycles later out_valid=1, out_sum=4, out_err=0, out_exceed=0; txn_count=1 after the handshake.
- Same operands, mode=1 (K=1) -> out_sum=5, out_err=1; mode=2 -> out_sum=2, out_err=2; max_err=2.
- K=2, ET=4, a=3, b=3, mode=2 -> out_sum=0, out_err=6, out_exceed=1, exceed_count increments.
  - Then a=7, b=7, mode=1 -> out_sum=15, out_err=1.
- Streaming and backpressure:
  - Stream 8 back-to-back transactions with out_ready low for cycles 3-6.
  - Required: in_ready drops once both stages are full.
  - Outputs appear in order with held values; txn_count=8 at the end.
- Assert rst while both stages are valid -> next cycle out_valid=0 and all counters 0.
- CNT_W=2, 5 handshakes -> txn_count saturates at 3.
  - stats_clr coincident with a handshake -> all statistics 0.
